// File: rtl/mulsub_sched.sv
`default_nettype none
// ============================================================================
// Module      : mulsub_sched
// Description : Round-robin issue scheduler for a shared pipelined
//               multiply-subtract unit (K*A - B) with credit-based result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mulsub_sched #(
  parameter int NREQ      = 4,
  parameter int NX        = 8,
  parameter int LAT       = 2,
  parameter int DEPTH     = 4,
  parameter int K_DEFAULT = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*NX-1:0]      req_a,
  input  logic [NREQ*NX-1:0]      req_b,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    cfg_we,
  input  logic [NX-1:0]           cfg_k,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [NX-1:0]           res_data,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    busy
);

  localparam int c_id_w = $clog2(NREQ);
  localparam int c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw   = $clog2(DEPTH + 1);

  logic [c_id_w-1:0] r_ptr;
  logic [NX-1:0]     r_k;
  logic [c_cw-1:0]   r_inflight;
  logic [c_cw-1:0]   r_cnt;
  logic [c_aw-1:0]   r_wp;
  logic [c_aw-1:0]   r_rp;
  logic [NX-1:0]     r_mem_d  [DEPTH];
  logic [c_id_w-1:0] r_mem_id [DEPTH];

  logic              r_s0_vld;
  logic [NX-1:0]     r_s0_a;
  logic [NX-1:0]     r_s0_b;
  logic [NX-1:0]     r_s0_k;
  logic [c_id_w-1:0] r_s0_id;

  logic              w_credit;
  logic              w_accept;
  logic [c_id_w-1:0] w_gid;
  logic [c_id_w-1:0] w_scan;
  logic [NREQ-1:0]   w_grant;
  logic [NX-1:0]     w_s0_res;
  logic              w_push;
  logic [NX-1:0]     w_push_d;
  logic [c_id_w-1:0] w_push_id;
  logic              w_pop;

  // Credit counts ops in flight plus queued results, so the FIFO never overflows.
  assign w_credit = rst_n && ((32'(r_inflight) + 32'(r_cnt)) < 32'(DEPTH));

  always_comb begin
    w_grant  = '0;
    w_accept = 1'b0;
    w_gid    = '0;
    w_scan   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = c_id_w'((32'(r_ptr) + 32'(k)) % NREQ);
      if (!w_accept && w_credit && req_valid[w_scan]) begin
        w_grant[w_scan] = 1'b1;
        w_gid           = w_scan;
        w_accept        = 1'b1;
      end
    end
  end

  assign req_ready = w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_k      <= NX'(K_DEFAULT);
      r_s0_vld <= 1'b0;
      r_s0_a   <= '0;
      r_s0_b   <= '0;
      r_s0_k   <= '0;
      r_s0_id  <= '0;
    end else begin
      if (cfg_we)
        r_k <= cfg_k;
      r_s0_vld <= w_accept;
      if (w_accept) begin
        r_ptr   <= (w_gid == c_id_w'(NREQ - 1)) ? '0 : w_gid + 1'b1;
        r_s0_a  <= req_a[w_gid*NX +: NX];
        r_s0_b  <= req_b[w_gid*NX +: NX];
        r_s0_k  <= r_k;
        r_s0_id <= w_gid;
      end
    end
  end

  assign w_s0_res = r_s0_k * r_s0_a - r_s0_b;

  generate
    if (LAT > 1) begin : g_tail
      logic [LAT-2:0]    r_tv;
      logic [NX-1:0]     r_td [LAT-1];
      logic [c_id_w-1:0] r_ti [LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tv <= '0;
          for (int j = 0; j < LAT - 1; j++) begin
            r_td[j] <= '0;
            r_ti[j] <= '0;
          end
        end else begin
          r_tv[0] <= r_s0_vld;
          r_td[0] <= w_s0_res;
          r_ti[0] <= r_s0_id;
          for (int j = 1; j < LAT - 1; j++) begin
            r_tv[j] <= r_tv[j-1];
            r_td[j] <= r_td[j-1];
            r_ti[j] <= r_ti[j-1];
          end
        end
      end

      assign w_push    = r_tv[LAT-2];
      assign w_push_d  = r_td[LAT-2];
      assign w_push_id = r_ti[LAT-2];
    end else begin : g_notail
      assign w_push    = r_s0_vld;
      assign w_push_d  = w_s0_res;
      assign w_push_id = r_s0_id;
    end
  endgenerate

  assign res_valid = (r_cnt != '0);
  assign w_pop     = res_valid && res_ready;
  // Gating keeps the outputs at zero while empty, including straight after reset.
  assign res_data  = res_valid ? r_mem_d[r_rp]  : '0;
  assign res_id    = res_valid ? r_mem_id[r_rp] : '0;
  assign busy      = (r_inflight != '0) || (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d[r_wp]  <= w_push_d;
      r_mem_id[r_wp] <= w_push_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_cnt      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
    end else begin
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_cnt == c_cw'(DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_mulsub_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mulsub_sched
// Description : Directed self-checking bench for mulsub_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mulsub_sched;

  localparam int NREQ = 4;
  localparam int NX   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*NX-1:0] req_a;
  logic [NREQ*NX-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              cfg_we;
  logic [NX-1:0]     cfg_k;
  logic              res_valid;
  logic              res_ready;
  logic [NX-1:0]     res_data;
  logic [1:0]        res_id;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int acc    = 0;
  logic [3:0] bp_exp [8] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100,
                             4'b0000, 4'b0000, 4'b0000, 4'b0000};

  always #5 clk = ~clk;

  mulsub_sched #(.NREQ(NREQ), .NX(NX), .LAT(2), .DEPTH(4), .K_DEFAULT(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .cfg_we    (cfg_we),
    .cfg_k     (cfg_k),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*NX +: NX] = a;
    req_b[i*NX +: NX] = b;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_k     = '0;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data",  res_data,  0);
    chk("rst_id",    res_id,    0);
    chk("rst_busy",  busy,      0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // basic op: 5*3-2
    set_req(0, 8'd3, 8'd2);
    req_valid = 4'b0001;
    #1 chk("basic_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("basic_busy_inflight", busy, 1);
    chk("basic_lat1", res_valid, 0);
    tick();
    chk("basic_lat2", res_valid, 0);
    tick();
    chk("basic_valid", res_valid, 1);
    chk("basic_data",  res_data,  13);
    chk("basic_id",    res_id,    0);
    tick();
    chk("basic_drain_valid", res_valid, 0);
    chk("basic_drain_busy",  busy,      0);

    // wrap cases
    set_req(1, 8'd200, 8'd10);
    req_valid = 4'b0010;
    #1 chk("wrap1_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("wrap1_data", res_data, 222);
    chk("wrap1_id",   res_id,   1);
    tick();
    set_req(2, 8'd0, 8'd1);
    req_valid = 4'b0100;
    #1 chk("wrap2_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("wrap2_data", res_data, 255);
    chk("wrap2_id",   res_id,   2);
    tick();

    // round-robin from a fresh pointer
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd0);
    req_valid = 4'hF;
    #1 chk("rr_g0", req_ready, 4'b0001);
    tick();
    chk("rr_g1", req_ready, 4'b0010);
    chk("rr_empty", res_valid, 0);
    tick();
    chk("rr_g2", req_ready, 4'b0100);
    tick();
    chk("rr_g3", req_ready, 4'b1000);
    chk("rr_r0_data", res_data, 5);
    chk("rr_r0_id",   res_id,   0);
    tick();
    chk("rr_g4_wrap", req_ready, 4'b0001);
    chk("rr_r1_data", res_data, 10);
    chk("rr_r1_id",   res_id,   1);
    req_valid = '0;
    tick();
    chk("rr_r2_data", res_data, 15);
    chk("rr_r2_id",   res_id,   2);
    tick();
    chk("rr_r3_data", res_data, 20);
    chk("rr_r3_id",   res_id,   3);
    tick();
    chk("rr_done", res_valid, 0);

    // backpressure: credit limits to DEPTH outstanding ops
    res_ready = 1'b0;
    set_req(1, 8'd6, 8'd1);
    set_req(2, 8'd7, 8'd3);
    req_valid = 4'b0110;
    #1;
    for (int c = 0; c < 8; c++) begin
      chk("bp_ready", req_ready, bp_exp[c]);
      if (c >= 3) begin
        chk("bp_hold_valid", res_valid, 1);
        chk("bp_hold_data",  res_data,  29);
        chk("bp_hold_id",    res_id,    1);
      end
      acc += (|(req_ready & req_valid)) ? 1 : 0;
      tick();
    end
    chk("bp_accepts", acc, 4);
    res_ready = 1'b1;
    #1 chk("bp_no_same_cycle_credit", req_ready, 0);
    tick();
    chk("bp_resume", req_ready, 4'b0010);
    chk("bp_r1_data", res_data, 32);
    chk("bp_r1_id",   res_id,   2);
    req_valid = '0;
    tick();
    chk("bp_r2_data", res_data, 29);
    tick();
    chk("bp_r3_data", res_data, 32);
    tick();
    chk("bp_done_valid", res_valid, 0);
    chk("bp_done_busy",  busy,      0);

    // config write coincident with acceptance
    set_req(0, 8'd4, 8'd0);
    req_valid = 4'b0001;
    cfg_we    = 1'b1;
    cfg_k     = 8'd2;
    #1 chk("cfg_ready0", req_ready, 4'b0001);
    tick();
    cfg_we = 1'b0;
    #1 chk("cfg_ready1", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    chk("cfg_old_k", res_data, 20);
    tick();
    chk("cfg_new_k", res_data, 8);
    tick();
    chk("cfg_done", res_valid, 0);

    // reset with two ops in flight and one queued
    res_ready = 1'b0;
    set_req(1, 8'd9, 8'd0);
    req_valid = 4'b0010;
    tick();
    tick();
    tick();
    req_valid = '0;
    chk("mid_pre_valid", res_valid, 1);
    chk("mid_pre_busy",  busy,      1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_busy",  busy,      0);
    chk("mid_rst_data",  res_data,  0);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mid_no_stale", res_valid, 0);
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd0);
    req_valid = 4'hF;
    #1 chk("mid_grant0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("mid_k_reset_data", res_data, 5);
    chk("mid_k_reset_id",   res_id,   0);
    tick();
    chk("mid_final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
